nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq.sv | 149 ++++++++++++++
 tb/tb_nibble_add_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - WIDTH-bit add/subtract sequenced through one 4-bit ripple-carry slice

// 4-bit ripple-carry adder slice shared across all nibble steps.
module nibble_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic rip;

  // Ripple the carry bit by bit through the four full adders.
  always_comb begin
    rip = cin;
    s   = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ rip;
      rip  = (a[i] & b[i]) | (rip & (a[i] ^ b[i]));
    end
    cout = rip;
  end

endmodule

// Sequencer: accepts one operation, runs NIBS nibble steps, holds the result until taken.
module nibble_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBS = WIDTH / 4;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic [CW-1:0]    nib_cnt;
  logic             sa;
  logic             sb;

  logic [3:0]       slice_s;
  logic             slice_co;
  logic             last_nib;
  logic             accept;

  // The only adder in the block; it always sees the low nibble of the shifters.
  nibble_rca4 u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );

  assign last_nib = (nib_cnt == LAST_NIB);
  assign accept   = (state == S_IDLE) && req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; leaving RUN is the only way the nibble count stops.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_RUN;
      S_RUN:   if (last_nib)  state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, then one nibble per cycle, LSB first.
  // Subtract is folded into the load: invert B and the borrow so RUN only ever adds.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      nib_cnt <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b ^ {WIDTH{sub}};
            carry   <= cin ^ sub;
            sa      <= a[WIDTH-1];
            sb      <= b[WIDTH-1] ^ sub;
            nib_cnt <= '0;
          end
        end
        S_RUN: begin
          a_sh    <= {4'b0000, a_sh[WIDTH-1:4]};
          b_sh    <= {4'b0000, b_sh[WIDTH-1:4]};
          sum_r   <= {slice_s, sum_r[WIDTH-1:4]};
          carry   <= slice_co;
          nib_cnt <= last_nib ? '0 : nib_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign sum       = sum_r;
  assign cout      = carry;
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf       = (state == S_DONE) && (sa == sb) && (sum_r[WIDTH-1] != sa);

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - randomized self-checking bench for nibble_add_seq
module tb_nibble_add_seq;

  localparam int W    = 32;
  localparam int NIBS = W / 4;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           t_acc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   last_acc = -1;
  bit   b2b = 0;
  bit   chk_rst = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic su);
    logic [W:0] full;
    longint     sr;
    longint     c;
    logic       ov;
    c = ci ? 1 : 0;
    if (!su) begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      sr   = longint'($signed(x)) + longint'($signed(y)) + c;
    end else begin
      full = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~ci};
      sr   = longint'($signed(x)) - longint'($signed(y)) - c;
    end
    ov = (sr > SMAX) || (sr < SMIN);
    return {full[W], ov, full[W-1:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: expected protocol state and results from the transaction queue.
  always @(negedge clk) begin
    logic  pend;
    logic  exp_rv;
    logic [W+1:0] m;
    exp_t  e;
    if (chk_rst) begin
      check("rst_res_valid", res_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      chk_rst = 0;
    end
    if (reset) begin
      q.delete();
      chk_rst = 1;
      last_acc = -1;
    end else begin
      pend = (q.size() != 0);
      check("req_ready", req_ready, !pend);
      check("busy", busy, pend);
      exp_rv = pend && ((cyc - q[0].t_acc) >= NIBS);
      check("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        check("sum", sum, q[0].s);
        check("cout", cout, q[0].co);
        check("ovf", ovf, q[0].ov);
      end
      if (res_valid && res_ready && pend) void'(q.pop_front());
      if (req_valid && req_ready) begin
        m = model(a, b, cin, sub);
        e.s = m[W-1:0];
        e.ov = m[W];
        e.co = m[W+1];
        e.t_acc = cyc + 1;
        q.push_back(e);
        n_acc++;
        if (b2b && last_acc >= 0) check("interval", cyc + 1 - last_acc, NIBS + 2);
        last_acc = b2b ? cyc + 1 : -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic su, input logic [W+1:0] exp, input bit lit);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    check("ready_before_op", req_ready, 1);
    a = x; b = y; cin = ci; sub = su; req_valid = 1;
    tick();
    req_valid = 0;
    k = 0;
    while (!res_valid && k < 50) begin tick(); k++; end
    check("edges_to_result", k + 1, NIBS + 1);
    if (lit) begin
      check("lit_sum", sum, exp[W-1:0]);
      check("lit_ovf", ovf, exp[W]);
      check("lit_cout", cout, exp[W+1]);
    end
    if (res_ready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W+1:0] m;
    int base;
    reset = 1; req_valid = 0; res_ready = 1;
    a = '0; b = '0; cin = 0; sub = 0;
    repeat (3) tick();
    reset = 0;
    tick();

    // Pin the reference model to hand-computed results.
    check("pin_add_wrap",  model(32'hFFFFFFFF, 32'h1, 0, 0), {2'b10, 32'h00000000});
    check("pin_add_ovf",   model(32'h7FFFFFFF, 32'h1, 0, 0), {2'b01, 32'h80000000});
    check("pin_add_cin",   model(32'h12345678, 32'h11111111, 1, 0), {2'b00, 32'h2345678A});
    check("pin_sub_neg",   model(32'h5, 32'h7, 0, 1), {2'b00, 32'hFFFFFFFE});
    check("pin_sub_ovf",   model(32'h80000000, 32'h1, 0, 1), {2'b11, 32'h7FFFFFFF});
    check("pin_sub_borrow", model(32'h0, 32'h0, 1, 1), {2'b00, 32'hFFFFFFFF});

    // Directed operations with literal expectations.
    do_op(32'hFFFFFFFF, 32'h1, 0, 0, {2'b10, 32'h00000000}, 1);
    do_op(32'h7FFFFFFF, 32'h1, 0, 0, {2'b01, 32'h80000000}, 1);
    do_op(32'h12345678, 32'h11111111, 1, 0, {2'b00, 32'h2345678A}, 1);
    do_op(32'h5, 32'h7, 0, 1, {2'b00, 32'hFFFFFFFE}, 1);
    do_op(32'h80000000, 32'h1, 0, 1, {2'b11, 32'h7FFFFFFF}, 1);

    // Backpressure: result held while inputs churn.
    res_ready = 0;
    m = model(32'hDEADBEEF, 32'h01234567, 1, 1);
    do_op(32'hDEADBEEF, 32'h01234567, 1, 1, m, 1);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
      req_valid = ~req_valid;
      tick();
      check("bp_sum", sum, m[W-1:0]);
      check("bp_req_ready", req_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    res_ready = 1; req_valid = 0;
    tick();
    check("bp_release_ready", req_ready, 1);
    check("bp_release_valid", res_valid, 0);

    // Reset mid-RUN aborts the operation.
    a = 32'hAAAA5555; b = 32'h00001234; cin = 0; sub = 0; req_valid = 1;
    tick();
    req_valid = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort_res_valid", res_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    do_op(32'h3, 32'h4, 0, 0, {2'b00, 32'h00000007}, 1);

    // Back-to-back random operations with req_valid held high.
    res_ready = 1;
    b2b = 1;
    base = n_acc;
    a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
    req_valid = 1;
    for (int c = 0; c < 3000 && n_acc < base + 200; c++) begin
      tick();
      a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
    end
    req_valid = 0;
    b2b = 0;
    check("b2b_count", n_acc - base, 200);
    for (int k = 0; k < 50 && busy; k++) tick();
    check("drained", busy, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
